keypad_scanner_mxn: RTL and testbench

- Parametrised matrix keypad scanner, the next generation of the 4x4 hex keypad scanner. Supports any row/column count.
- Integrates the row synchronizer and adds debounce, multi-key (ghost) rejection and key-release events.
- Drives the column lines, samples the row lines and reports one debounced key code with press and release strobes.
- Sits between the board-level keypad matrix and the system's input/event logic.

---
 rtl/keypad_scanner_mxn.sv | 158 +++++++++++++++
 tb/tb_keypad_scanner_mxn.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/keypad_scanner_mxn.sv
// Parametrised matrix keypad scanner: synchronizes rows, scans columns, debounces
// a single key and reports press/release strobes with multi-key (ghost) detection.
module keypad_scanner_mxn #(
  parameter int N_ROWS       = 4,
  parameter int N_COLS       = 4,
  parameter int SETTLE_CYC   = 2,
  parameter int DEBOUNCE_CYC = 4,
  parameter int CODE_W       = $clog2(N_ROWS*N_COLS)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [N_ROWS-1:0] row_in,
  output logic [N_COLS-1:0] col_out,
  output logic [CODE_W-1:0] code,
  output logic              valid,
  output logic              press_stb,
  output logic              release_stb,
  output logic              multi_key
);
  // state    | meaning
  // IDLE     | all columns driven, waiting for any row activity
  // SCAN     | one column driven, settle then sample rows
  // DEBOUNCE | single key found, confirming a stable press
  // HELD     | key accepted, all columns driven, waiting for a stable release
  localparam int COL_W   = (N_COLS > 1) ? $clog2(N_COLS) : 1;
  localparam int ROW_W   = (N_ROWS > 1) ? $clog2(N_ROWS) : 1;
  localparam int CNT_MAX = (SETTLE_CYC > DEBOUNCE_CYC) ? SETTLE_CYC : DEBOUNCE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC);
  localparam logic [CNT_W-1:0] DEB_LD    = CNT_W'(DEBOUNCE_CYC);

  typedef enum logic [1:0] {IDLE, SCAN, DEBOUNCE, HELD} state_t;
  state_t state, state_nx;

  logic [N_ROWS-1:0] sync_q, s_row;
  logic [N_ROWS-1:0] sample, sample_nx;
  logic [COL_W-1:0]  col, col_nx;
  logic [CNT_W-1:0]  cnt, cnt_nx;
  logic [CODE_W-1:0] code_nx;
  logic              valid_nx, press_nx, release_nx, multi_nx;
  logic              row_zero, row_one;
  logic [ROW_W-1:0]  row_idx;

  assign row_zero = (s_row == '0);
  assign row_one  = !row_zero && ((s_row & (s_row - N_ROWS'(1))) == '0);

  always_comb begin
    row_idx = '0;
    for (int r = 0; r < N_ROWS; r++)
      if (sample[r]) row_idx = ROW_W'(r);
  end

  always_comb begin
    col_out = '1;
    if (state == SCAN || state == DEBOUNCE) col_out = N_COLS'(1) << col;
  end

  always_comb begin
    state_nx   = state;
    col_nx     = col;
    cnt_nx     = cnt;
    sample_nx  = sample;
    code_nx    = code;
    valid_nx   = valid;
    press_nx   = 1'b0;
    release_nx = 1'b0;
    multi_nx   = multi_key;
    case (state)
      IDLE: begin
        cnt_nx = '0;
        if (row_zero) begin
          multi_nx = 1'b0;
        end else begin
          state_nx = SCAN;
          col_nx   = '0;
          cnt_nx   = SETTLE_LD;
        end
      end
      SCAN: begin
        if (cnt != '0) begin
          cnt_nx = cnt - CNT_W'(1);
        end else if (row_zero) begin
          if (col == COL_W'(N_COLS-1)) begin
            state_nx = IDLE;
          end else begin
            col_nx = col + COL_W'(1);
            cnt_nx = SETTLE_LD;
          end
        end else if (row_one) begin
          sample_nx = s_row;
          cnt_nx    = DEB_LD;
          state_nx  = DEBOUNCE;
        end else begin
          multi_nx = 1'b1;
          state_nx = IDLE;
        end
      end
      DEBOUNCE: begin
        if (s_row != sample) begin
          state_nx = IDLE;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(1)) begin
          code_nx  = CODE_W'(int'(row_idx) * N_COLS + int'(col));
          valid_nx = 1'b1;
          press_nx = 1'b1;
          cnt_nx   = DEB_LD;
          state_nx = HELD;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      HELD: begin
        // only rows other than the accepted one can reveal a second key here
        if ((s_row & ~sample) != '0) multi_nx = 1'b1;
        if (!row_zero) begin
          cnt_nx = DEB_LD;
        end else if (cnt == CNT_W'(1)) begin
          valid_nx   = 1'b0;
          release_nx = 1'b1;
          cnt_nx     = '0;
          state_nx   = IDLE;
        end else begin
          cnt_nx = cnt - CNT_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sync_q      <= '0;
      s_row       <= '0;
      state       <= IDLE;
      col         <= '0;
      cnt         <= '0;
      sample      <= '0;
      code        <= '0;
      valid       <= 1'b0;
      press_stb   <= 1'b0;
      release_stb <= 1'b0;
      multi_key   <= 1'b0;
    end else begin
      sync_q      <= row_in;
      s_row       <= sync_q;
      state       <= state_nx;
      col         <= col_nx;
      cnt         <= cnt_nx;
      sample      <= sample_nx;
      code        <= code_nx;
      valid       <= valid_nx;
      press_stb   <= press_nx;
      release_stb <= release_nx;
      multi_key   <= multi_nx;
    end
  end

endmodule

// File: tb/tb_keypad_scanner_mxn.sv
// Directed bench for keypad_scanner_mxn: a 4x4 and a 3x5 instance driven by a
// passive key-matrix model, checked with immediate assertions.
module tb_keypad_scanner_mxn;
  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] row_in, col_out, code;
  logic       valid, press_stb, release_stb, multi_key;
  logic [2:0] row_in2;
  logic [4:0] col_out2;
  logic [3:0] code2;
  logic       valid2, press_stb2, release_stb2, multi_key2;

  logic [15:0] pressed;
  logic [14:0] pressed2;

  int n_cmp = 0, n_mis = 0;
  int press_cnt = 0, release_cnt = 0, both_hi = 0;
  int press_cnt2 = 0, release_cnt2 = 0, both_hi2 = 0;
  logic [3:0] press_code = '0;

  always #5 clock = ~clock;

  keypad_scanner_mxn dut (
    .clock(clock), .reset(reset), .row_in(row_in), .col_out(col_out), .code(code),
    .valid(valid), .press_stb(press_stb), .release_stb(release_stb), .multi_key(multi_key)
  );

  keypad_scanner_mxn #(.N_ROWS(3), .N_COLS(5)) dut2 (
    .clock(clock), .reset(reset), .row_in(row_in2), .col_out(col_out2), .code(code2),
    .valid(valid2), .press_stb(press_stb2), .release_stb(release_stb2), .multi_key(multi_key2)
  );

  // a row reads high when any pressed key in it sits on a driven column
  always_comb begin
    for (int r = 0; r < 4; r++) row_in[r] = |(pressed[r*4 +: 4] & col_out);
    for (int r = 0; r < 3; r++) row_in2[r] = |(pressed2[r*5 +: 5] & col_out2);
  end

  always @(posedge clock) begin
    if (press_stb) begin press_cnt++; press_code = code; end
    if (release_stb) release_cnt++;
    if (press_stb && release_stb) both_hi++;
    if (press_stb2) press_cnt2++;
    if (release_stb2) release_cnt2++;
    if (press_stb2 && release_stb2) both_hi2++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  initial begin
    pressed  = '0;
    pressed2 = '0;
    reset    = 1'b1;
    cycles(3);
    check("rst_col_out", 32'(col_out), 32'hF);
    check("rst_code", 32'(code), 32'h0);
    check("rst_valid", 32'(valid), 32'h0);
    check("rst_multi", 32'(multi_key), 32'h0);
    check("rst_col_out2", 32'(col_out2), 32'h1F);
    reset = 1'b0;

    cycles(50);
    check("idle_col_out", 32'(col_out), 32'hF);
    check("idle_valid", 32'(valid), 32'h0);
    check("idle_press_cnt", press_cnt, 0);
    check("idle_release_cnt", release_cnt, 0);

    pressed[6] = 1'b1;
    cycles(40);
    check("k6_press_cnt", press_cnt, 1);
    check("k6_press_code", 32'(press_code), 32'd6);
    check("k6_valid", 32'(valid), 32'h1);
    check("k6_no_early_release", release_cnt, 0);
    pressed = '0;
    cycles(30);
    check("k6_release_cnt", release_cnt, 1);
    check("k6_valid_low", 32'(valid), 32'h0);
    check("k6_code_kept", 32'(code), 32'd6);

    for (int k = 0; k < 16; k++) begin
      pressed = 16'd1 << k;
      cycles(40);
      check("sweep_press_cnt", press_cnt, 2 + k);
      check("sweep_code", 32'(press_code), 32'(k));
      check("sweep_valid", 32'(valid), 32'h1);
      check("sweep_held_no_release", release_cnt, 1 + k);
      pressed = '0;
      cycles(30);
      check("sweep_release_cnt", release_cnt, 2 + k);
      check("sweep_valid_low", 32'(valid), 32'h0);
    end

    pressed[9] = 1'b1;
    cycles(3);
    pressed = '0;
    cycles(30);
    check("glitch_no_press", press_cnt, 17);
    check("glitch_valid", 32'(valid), 32'h0);
    check("glitch_idle_cols", 32'(col_out), 32'hF);

    pressed[5] = 1'b1;
    cycles(40);
    check("k5_press_cnt", press_cnt, 18);
    check("k5_code", 32'(code), 32'd5);
    check("k5_multi_low", 32'(multi_key), 32'h0);
    pressed[10] = 1'b1;
    cycles(20);
    check("k5k10_multi", 32'(multi_key), 32'h1);
    check("k5k10_code", 32'(code), 32'd5);
    check("k5k10_valid", 32'(valid), 32'h1);
    check("k5k10_no_new_press", press_cnt, 18);
    pressed = '0;
    cycles(30);
    check("k5k10_release_cnt", release_cnt, 18);
    check("k5k10_valid_low", 32'(valid), 32'h0);
    check("k5k10_multi_clear", 32'(multi_key), 32'h0);

    pressed[3]   = 1'b1;
    pressed2[14] = 1'b1;
    cycles(40);
    check("k3_valid", 32'(valid), 32'h1);
    check("k3_code", 32'(code), 32'd3);
    check("d2_press_cnt", press_cnt2, 1);
    check("d2_code", 32'(code2), 32'd14);
    check("d2_valid", 32'(valid2), 32'h1);
    #2 reset = 1'b1;
    #1;
    check("async_rst_valid", 32'(valid), 32'h0);
    check("async_rst_code", 32'(code), 32'h0);
    check("async_rst_col_out", 32'(col_out), 32'hF);
    check("async_rst_valid2", 32'(valid2), 32'h0);
    check("async_rst_code2", 32'(code2), 32'h0);
    check("async_rst_col_out2", 32'(col_out2), 32'h1F);
    pressed  = '0;
    pressed2 = '0;
    cycles(3);
    reset = 1'b0;
    cycles(30);
    check("rst_no_release", release_cnt, 18);
    check("rst_no_release2", release_cnt2, 0);
    check("rst_valid_after", 32'(valid), 32'h0);
    check("strobe_overlap", both_hi, 0);
    check("strobe_overlap2", both_hi2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
